// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle, LSB digit first,
// with a valid/ready handshake on both the operand and result sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1, last result held
  // RUN   | adding one digit per cycle, counter selects the digit
  // DONE  | result valid, held until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsum;
  logic             last_dig, accept, msb_carry_in;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  assign dsum         = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the MSB recovered from the sum bit and its two operand bits.
  assign msb_carry_in = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
  assign last_dig     = (cnt_q == CW'(N - 1));
  assign accept       = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_dig)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CW'(k)) begin
          s_q[k*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
        end
      end
      carry_q <= dsum[DIGIT];
      if (last_dig) begin
        cout_q <= dsum[DIGIT];
        ovf_q  <= msb_carry_in ^ dsum[DIGIT];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed corner cases plus random operations
// checked against a plain-arithmetic model, on DIGIT=4, 16 and 1 instances.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;

  logic        x_in_valid, x_cin, x_sub, x_out_ready;
  logic [15:0] x_a, x_b;
  logic        w_in_ready, w_out_valid, w_cout, w_ovf;
  logic        n_in_ready, n_out_valid, n_cout, n_ovf;
  logic [15:0] w_s, n_s;

  int total = 0;
  int bad   = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(w_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(w_out_valid),
    .out_ready(x_out_ready), .s(w_s), .cout(w_cout), .ovf(w_ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(n_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(n_out_valid),
    .out_ready(x_out_ready), .s(n_s), .cout(n_cout), .ovf(n_ovf)
  );

  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic cv, input logic sv,
                                output logic [15:0] so, output logic co,
                                output logic ov);
    int sa, sb, r;
    logic [16:0] u;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      so = av - bv;
      co = (av >= bv);
      r  = sa - sb;
    end else begin
      u  = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
      so = u[15:0];
      co = u[16];
      r  = sa + sb + int'(cv);
    end
    ov = (r > 32767) || (r < -32768);
  endfunction

  task automatic scramble();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Accepts one operation on the DIGIT=4 instance and waits for out_valid.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv,
                        output logic [15:0] so, output logic co,
                        output logic ov, output int lat);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    so = s; co = cout; ov = ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] so; logic co, ov; int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in_valid = 1'b0; x_out_ready = 1'b0;
    a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0;
    x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, s, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b s=%h co=%b ov=%b, want rdy=1 vld=0 s=0000 co=0 ov=0",
               in_ready, out_valid, s, cout, ovf);
    end
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL first_accept: in_ready=%b after first edge, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    so = s; co = cout; ov = ovf;
    total++;
    if (so !== 16'h0007 || lat != 4) begin
      bad++;
      $display("FAIL first_result: s=%h lat=%0d, want s=0007 lat=4", so, lat);
    end
    release_out();
  endtask

  typedef struct {
    logic [15:0] av, bv; logic cv, sv;
    logic [15:0] es; logic ec, eo;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    logic [15:0] so; logic co, ov; int lat;
    v[0] = '{16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].av, v[i].bv, v[i].cv, v[i].sv, so, co, ov, lat);
      total++;
      if (so !== v[i].es || co !== v[i].ec || ov !== v[i].eo || lat != 4) begin
        bad++;
        $display("FAIL directed_%0d: s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=4",
                 i, so, co, ov, lat, v[i].es, v[i].ec, v[i].eo);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [15:0] av, bv, so, es; logic cv, sv, co, ov, ec, eo; int lat, hold;
    for (int i = 0; i < 60; i++) begin
      av = 16'($urandom); bv = 16'($urandom);
      cv = 1'($urandom);  sv = 1'($urandom);
      model(av, bv, cv, sv, es, ec, eo);
      run_op(av, bv, cv, sv, so, co, ov, lat);
      total++;
      if (so !== es || co !== ec || ov !== eo || lat != 4) begin
        bad++;
        $display("FAIL random_%0d: %h op%0d %h cin=%b -> s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=4",
                 i, av, sv, bv, cv, so, co, ov, lat, es, ec, eo);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      total++;
      if (out_valid !== 1'b1 || s !== es) begin
        bad++;
        $display("FAIL random_hold_%0d: vld=%b s=%h after %0d stall cycles, want vld=1 s=%h",
                 i, out_valid, s, hold, es);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e1, e2, so, a2, b2; logic c1, o1, c2, o2, co, ov, cv2, sv2; int lat;
    model(16'h4321, 16'h1111, 1'b1, 1'b0, e1, c1, o1);
    run_op(16'h4321, 16'h1111, 1'b1, 1'b0, so, co, ov, lat);
    a2 = 16'($urandom); b2 = 16'($urandom); cv2 = 1'($urandom); sv2 = 1'($urandom);
    model(a2, b2, cv2, sv2, e2, c2, o2);
    a = a2; b = b2; cin = cv2; sub = sv2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== e1 || cout !== c1 || ovf !== o1) begin
        bad++;
        $display("FAIL stall_%0d: vld=%b rdy=%b s=%h co=%b ov=%b, want vld=1 rdy=0 s=%h co=%b ov=%b",
                 i, out_valid, in_ready, s, cout, ovf, e1, c1, o1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake_edge: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL next_accept: rdy=%b one edge after handshake, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (s !== e2 || cout !== c2 || ovf !== o2 || lat != 4) begin
      bad++;
      $display("FAIL next_result: s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=4",
               s, cout, ovf, lat, e2, c2, o2);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] av, bv, so, es; logic cv, sv, co, ov, ec, eo; int lat, seen;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, s, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: rdy=%b vld=%b s=%h co=%b ov=%b, want rdy=1 vld=0 s=0000 co=0 ov=0",
               in_ready, out_valid, s, cout, ovf);
    end
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL no_valid_after_reset: out_valid seen %0d cycles, want 0", seen);
    end
    av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom); sv = 1'($urandom);
    model(av, bv, cv, sv, es, ec, eo);
    run_op(av, bv, cv, sv, so, co, ov, lat);
    total++;
    if (so !== es || co !== ec || ov !== eo || lat != 4) begin
      bad++;
      $display("FAIL post_reset_op: s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=4",
               so, co, ov, lat, es, ec, eo);
    end
    release_out();
  endtask

  task automatic test_digit_extremes();
    logic [15:0] av, bv, es; logic cv, sv, ec, eo; int lw, ln;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        av = 16'hFFFF; bv = 16'h0001; cv = 1'b0; sv = 1'b0;
      end else begin
        av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom); sv = 1'($urandom);
      end
      model(av, bv, cv, sv, es, ec, eo);
      x_a = av; x_b = bv; x_cin = cv; x_sub = sv; x_in_valid = 1'b1;
      @(posedge clk); #1;
      x_in_valid = 1'b0;
      x_a = 16'($urandom); x_b = 16'($urandom); x_cin = 1'($urandom); x_sub = 1'($urandom);
      lw = -1; ln = -1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (lw < 0 && w_out_valid) lw = c;
        if (ln < 0 && n_out_valid) ln = c;
        if (lw >= 0 && ln >= 0) break;
      end
      total++;
      if (w_s !== es || w_cout !== ec || w_ovf !== eo || lw != 1) begin
        bad++;
        $display("FAIL digit16_%0d: s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=1",
                 i, w_s, w_cout, w_ovf, lw, es, ec, eo);
      end
      total++;
      if (n_s !== es || n_cout !== ec || n_ovf !== eo || ln != 16) begin
        bad++;
        $display("FAIL digit1_%0d: s=%h co=%b ov=%b lat=%0d, want s=%h co=%b ov=%b lat=16",
                 i, n_s, n_cout, n_ovf, ln, es, ec, eo);
      end
      x_out_ready = 1'b1;
      @(posedge clk); #1;
      x_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_digit_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, with DIGIT >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 computes a+b+cin; 1 computes a+~b+1, which is a-b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: sum.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the MSB (for sub=1, 1 means no borrow).
REQ-014 The block SHALL have port ovf, output, 1 bit: signed overflow, defined as carry into the MSB XOR carry out of the MSB.

Function
REQ-015 The block SHALL implement a 3-state FSM with states IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-016 in_ready SHALL be 1 only in IDLE; operands are accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 On accept, the block SHALL register a, b (inverted if sub=1) and an initial carry (cin if sub=0, 1 if sub=1), clear the digit counter, and enter RUN.
REQ-018 In RUN, each cycle SHALL add digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1, LSB digit first, k = 0..N-1) plus the registered carry, write that slice of s, and register the digit carry-out.
REQ-019 After digit N-1 is added, the block SHALL enter DONE, and cout and ovf SHALL be set from the final digit.
REQ-020 out_valid SHALL be 1 exactly in DONE; out_valid SHALL rise N cycles after the accept edge (N=1 when DIGIT=WIDTH).
REQ-021 In DONE, s, cout and ovf SHALL hold stable until a rising edge with out_ready=1, which returns the FSM to IDLE.
REQ-022 s, cout and ovf SHALL keep their last values in IDLE, until the next accept.
REQ-023 in_valid SHALL be ignored in RUN and DONE; no new operands are accepted in the same cycle as the output handshake.
REQ-024 Operand inputs SHALL be sampled only at the accept edge; later changes to them SHALL have no effect on the result in progress.
REQ-025 The result SHALL be bit-exact to (a + b + cin) mod 2^WIDTH, or to (a - b) mod 2^WIDTH, for all WIDTH/DIGIT legal pairs.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force state to IDLE, and s, cout, ovf, out_valid, counter and carry to 0; in_ready SHALL be 1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid SHALL follow reset release.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-029 a=0x1234, b=0x0001, cin=0, sub=0 -> s=0x1235, cout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
REQ-030 a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0 (carry crosses all digit boundaries).
REQ-031 a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1; sub=1 with a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0; sub=1 with a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-032 Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> out_valid and s held, in_ready=0, new operands ignored; after out_ready=1 the next accept occurs one cycle later.
REQ-033 rst_n pulsed low during RUN digit 2 -> outputs go to 0 immediately without a clock edge, in_ready=1, and no out_valid follows; a fresh operation then completes correctly.
REQ-034 With DIGIT=16 (N=1) and with DIGIT=1 (N=16), the 0xFFFF+0x0001 case -> identical result, with latency 1 and 16 respectively.
